// File: rtl/rocket_slot_scheduler.sv
// Rocket slot pool shared between player and alien fire: fixed-priority grant of the
// lowest free slot, per-slot launch/fly lifecycle, and per-requester frame cooldowns.

module rocket_slot (
    input  logic               clk,
    input  logic               resetN,
    input  logic               clear,
    input  logic               grant,
    input  logic               release_in,
    input  logic               owner_in,
    input  logic signed [10:0] x_in,
    input  logic signed [10:0] y_in,
    input  logic signed [8:0]  speed_in,
    output logic               active,
    output logic               owner,
    output logic signed [10:0] init_x,
    output logic signed [10:0] init_y,
    output logic signed [8:0]  init_speed
);
    typedef enum logic [1:0] {FREE, LAUNCH0, LAUNCH1, FLYING} slot_state_t;

    slot_state_t state, next_state;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= FREE;
        else         state <= next_state;
    end

    // Release is only honoured in FLYING: the controller's position is stale while launching.
    always_comb begin
        next_state = state;
        case (state)
            FREE:    if (grant) next_state = LAUNCH0;
            LAUNCH0: next_state = LAUNCH1;
            LAUNCH1: next_state = FLYING;
            FLYING:  if (release_in) next_state = FREE;
            default: next_state = FREE;
        endcase
        if (clear) next_state = FREE;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            owner      <= 1'b0;
            init_x     <= '0;
            init_y     <= '0;
            init_speed <= '0;
        end else if (grant && !clear) begin
            owner      <= owner_in;
            init_x     <= x_in;
            init_y     <= y_in;
            init_speed <= speed_in;
        end
    end

    assign active = (state != FREE);
endmodule

module rocket_slot_scheduler #(
    parameter int              NUM_SLOTS       = 4,
    parameter int              MAX_ALIEN       = 2,
    parameter int              PLAYER_COOLDOWN = 8,
    parameter int              ALIEN_COOLDOWN  = 20,
    parameter logic signed [8:0] PLAYER_SPEED  = -9'sd256,
    parameter logic signed [8:0] ALIEN_SPEED   = 9'sd128
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              startOfFrame,
    input  logic                              gameClear,
    input  logic                              playerReq,
    input  logic signed [10:0]                playerX,
    input  logic signed [10:0]                playerY,
    output logic                              playerAck,
    input  logic                              alienReq,
    input  logic signed [10:0]                alienX,
    input  logic signed [10:0]                alienY,
    output logic                              alienAck,
    input  logic [NUM_SLOTS-1:0]              reachedBorder,
    input  logic [NUM_SLOTS-1:0]              hit,
    output logic [NUM_SLOTS-1:0]              isActive,
    output logic [11*NUM_SLOTS-1:0]           slotInitX,
    output logic [11*NUM_SLOTS-1:0]           slotInitY,
    output logic [9*NUM_SLOTS-1:0]            slotSpeed,
    output logic [NUM_SLOTS-1:0]              slotOwner,
    output logic [$clog2(NUM_SLOTS+1)-1:0]    activeCount
);
    localparam int CW  = $clog2(NUM_SLOTS+1);
    localparam int CDW = $clog2(((PLAYER_COOLDOWN > ALIEN_COOLDOWN) ? PLAYER_COOLDOWN : ALIEN_COOLDOWN) + 1);

    logic [NUM_SLOTS-1:0]              free, first_free, slot_grant;
    logic [NUM_SLOTS-1:0][10:0]        init_x, init_y;
    logic [NUM_SLOTS-1:0][8:0]         init_speed;
    logic [CW-1:0]                     alien_cnt;
    logic [CDW-1:0]                    player_cool, alien_cool;
    logic                              player_ok, alien_ok, grant_player, grant_alien;
    logic signed [10:0]                launch_x, launch_y;
    logic signed [8:0]                 launch_speed;

    // A slot released this cycle is still FLYING here, so it cannot be re-granted on the same edge.
    assign free       = ~isActive;
    assign first_free = free & (~free + NUM_SLOTS'(1));

    always_comb begin
        alien_cnt   = '0;
        activeCount = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            alien_cnt   = alien_cnt + CW'(isActive[i] & slotOwner[i]);
            activeCount = activeCount + CW'(isActive[i]);
        end
    end

    always_comb begin
        player_ok    = playerReq && (player_cool == '0) && (|free) && !gameClear;
        alien_ok     = alienReq && (alien_cool == '0) && (|free) && !gameClear
                       && (alien_cnt < CW'(MAX_ALIEN));
        grant_player = player_ok;
        grant_alien  = alien_ok && !player_ok;
        slot_grant   = (grant_player || grant_alien) ? first_free : '0;
        launch_x     = grant_alien ? alienX      : playerX;
        launch_y     = grant_alien ? alienY      : playerY;
        launch_speed = grant_alien ? ALIEN_SPEED : PLAYER_SPEED;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            playerAck <= 1'b0;
            alienAck  <= 1'b0;
        end else begin
            playerAck <= grant_player;
            alienAck  <= grant_alien;
        end
    end

    // A grant reloads the full cooldown even when it coincides with startOfFrame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            player_cool <= '0;
            alien_cool  <= '0;
        end else if (gameClear) begin
            player_cool <= '0;
            alien_cool  <= '0;
        end else begin
            if (grant_player)                          player_cool <= CDW'(PLAYER_COOLDOWN);
            else if (startOfFrame && player_cool != '0) player_cool <= player_cool - 1'b1;
            if (grant_alien)                           alien_cool  <= CDW'(ALIEN_COOLDOWN);
            else if (startOfFrame && alien_cool != '0)  alien_cool  <= alien_cool - 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        rocket_slot u_slot (
            .clk        (clk),
            .resetN     (resetN),
            .clear      (gameClear),
            .grant      (slot_grant[i]),
            .release_in (reachedBorder[i] | hit[i]),
            .owner_in   (grant_alien),
            .x_in       (launch_x),
            .y_in       (launch_y),
            .speed_in   (launch_speed),
            .active     (isActive[i]),
            .owner      (slotOwner[i]),
            .init_x     (init_x[i]),
            .init_y     (init_y[i]),
            .init_speed (init_speed[i])
        );
    end

    assign slotInitX = init_x;
    assign slotInitY = init_y;
    assign slotSpeed = init_speed;
endmodule

// File: tb/tb_rocket_slot_scheduler.sv
// Directed bench for rocket_slot_scheduler: grant/ack timing, cooldowns, priority,
// release timing, launch-window release masking, alien cap and gameClear.

module tb_rocket_slot_scheduler;
    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame, gameClear;
    logic               playerReq, alienReq;
    logic signed [10:0] playerX, playerY, alienX, alienY;
    logic               playerAck, alienAck;
    logic [3:0]         reachedBorder, hit, isActive, slotOwner;
    logic [43:0]        slotInitX, slotInitY;
    logic [35:0]        slotSpeed;
    logic [2:0]         activeCount;

    int n_cmp = 0;
    int n_err = 0;

    rocket_slot_scheduler dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .gameClear(gameClear),
        .playerReq(playerReq), .playerX(playerX), .playerY(playerY), .playerAck(playerAck),
        .alienReq(alienReq), .alienX(alienX), .alienY(alienY), .alienAck(alienAck),
        .reachedBorder(reachedBorder), .hit(hit), .isActive(isActive),
        .slotInitX(slotInitX), .slotInitY(slotInitY), .slotSpeed(slotSpeed),
        .slotOwner(slotOwner), .activeCount(activeCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; gameClear = 1'b0;
        playerReq = 1'b0; alienReq = 1'b0;
        playerX = '0; playerY = '0; alienX = '0; alienY = '0;
        reachedBorder = '0; hit = '0;
        repeat (3) tick();
        chk("rst_active", isActive, 4'b0000);
        chk("rst_count", activeCount, 3'd0);
        chk("rst_pack", playerAck, 1'b0);
        chk("rst_aack", alienAck, 1'b0);
        chk("rst_speed", slotSpeed, 36'h0);
        resetN = 1'b1;
        tick();

        // 1: first player shot goes to slot 0
        playerX = 11'sd320; playerY = 11'sd400; playerReq = 1'b1;
        chk("t1_ack_pre", playerAck, 1'b0);
        tick();
        chk("t1_ack", playerAck, 1'b1);
        chk("t1_active", isActive, 4'b0001);
        chk("t1_x0", slotInitX[10:0], 11'd320);
        chk("t1_y0", slotInitY[10:0], 11'd400);
        chk("t1_spd0", slotSpeed[8:0], 9'h100);  // -256
        chk("t1_own0", slotOwner[0], 1'b0);
        chk("t1_count", activeCount, 3'd1);
        playerReq = 1'b0;
        tick();
        chk("t1_ack_drop", playerAck, 1'b0);

        // 2: player cooldown holds off the second shot for 8 frames
        repeat (3) sof();
        playerX = 11'sd100; playerY = 11'sd200; playerReq = 1'b1;
        tick();
        chk("t2_cool_a", playerAck, 1'b0);
        for (int k = 0; k < 5; k++) begin
            sof();
            chk("t2_cool_b", playerAck, 1'b0);
        end
        tick();
        chk("t2_ack", playerAck, 1'b1);
        chk("t2_active", isActive, 4'b0011);
        chk("t2_x1", slotInitX[21:11], 11'd100);
        chk("t2_x0_hold", slotInitX[10:0], 11'd320);
        playerReq = 1'b0;

        // 3: simultaneous requests, player first, alien next cycle
        repeat (8) sof();
        playerX = 11'sd10; playerY = 11'sd20; alienX = 11'sd30; alienY = 11'sd40;
        playerReq = 1'b1; alienReq = 1'b1;
        tick();
        chk("t3_pack", playerAck, 1'b1);
        chk("t3_aack_wait", alienAck, 1'b0);
        chk("t3_active_a", isActive, 4'b0111);
        playerReq = 1'b0;
        tick();
        chk("t3_aack", alienAck, 1'b1);
        chk("t3_pack_drop", playerAck, 1'b0);
        chk("t3_active_b", isActive, 4'b1111);
        chk("t3_owner", slotOwner, 4'b1000);
        chk("t3_y3", slotInitY[43:33], 11'd40);
        chk("t3_spd3", slotSpeed[35:27], 9'd128);
        chk("t3_count", activeCount, 3'd4);
        alienReq = 1'b0;

        // 4: full pool; hit frees slot 2, which is granted a cycle later
        repeat (8) sof();
        playerX = 11'sd55; playerReq = 1'b1;
        tick();
        chk("t4_full", playerAck, 1'b0);
        hit = 4'b0100;
        tick();
        chk("t4_release", isActive, 4'b1011);
        chk("t4_no_same", playerAck, 1'b0);
        hit = '0;
        tick();
        chk("t4_ack", playerAck, 1'b1);
        chk("t4_active", isActive, 4'b1111);
        chk("t4_x2", slotInitX[32:22], 11'd55);
        playerReq = 1'b0;

        // 5: border ignored while launching, honoured once flying
        repeat (8) sof();
        playerX = 11'sd77; playerReq = 1'b1; hit = 4'b0001;
        tick();
        chk("t5_free0", isActive, 4'b1110);
        chk("t5_cnt3", activeCount, 3'd3);
        chk("t5_no_same", playerAck, 1'b0);
        hit = '0;
        tick();
        chk("t5_ack", playerAck, 1'b1);
        chk("t5_x0", slotInitX[10:0], 11'd77);
        playerReq = 1'b0; reachedBorder = 4'b0001;
        tick();
        chk("t5_l1_hold", isActive, 4'b1111);
        tick();
        chk("t5_fly_hold", isActive, 4'b1111);
        tick();
        chk("t5_border", isActive, 4'b1110);
        chk("t5_count", activeCount, 3'd3);
        reachedBorder = '0;

        // 6: alien cap, then gameClear over pending requests
        repeat (4) sof();
        alienX = 11'sd7; alienY = 11'sd9; alienReq = 1'b1;
        tick();
        chk("t6_aack", alienAck, 1'b1);
        chk("t6_owner", slotOwner, 4'b1001);
        alienReq = 1'b0; hit = 4'b0010;
        tick();
        chk("t6_free1", isActive, 4'b1101);
        hit = '0;
        repeat (20) sof();
        alienReq = 1'b1;
        tick();
        chk("t6_cap_a", alienAck, 1'b0);
        tick();
        chk("t6_cap_b", alienAck, 1'b0);
        chk("t6_cap_act", isActive, 4'b1101);
        playerReq = 1'b1; gameClear = 1'b1;
        tick();
        chk("t6_clr_act", isActive, 4'b0000);
        chk("t6_clr_cnt", activeCount, 3'd0);
        chk("t6_clr_pack", playerAck, 1'b0);
        chk("t6_clr_aack", alienAck, 1'b0);
        gameClear = 1'b0; alienReq = 1'b0;

        // gameClear also zeroes the cooldown just loaded
        playerX = 11'sd99;
        tick();
        chk("t7_ack", playerAck, 1'b1);
        playerReq = 1'b0; gameClear = 1'b1;
        tick();
        chk("t7_clr", isActive, 4'b0000);
        gameClear = 1'b0; playerReq = 1'b1;
        tick();
        chk("t7_cool_zero", playerAck, 1'b1);
        chk("t7_spd0", slotSpeed[8:0], 9'h100);
        playerReq = 1'b0;

        // asynchronous reset aborts flight immediately
        tick();
        #2 resetN = 1'b0;
        #1;
        chk("t8_async_rst", isActive, 4'b0000);
        chk("t8_rst_x", slotInitX[10:0], 11'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
